event_generator: RTL and testbench
==================================

Name: event_generator

Overview:
Programmable event (tick) source: the producer side of the event-count interface.
- Emits a train of TICK pulses with a programmable period and high time.
- Train is either a fixed number of events or free-running.
- Drives TICK inputs of downstream event counters; reports BUSY, a DONE pulse and a running count of events emitted.

Parameters:
PERIOD_WIDTH, 8, width of PERIOD and HIGH_TIME (cycles).
COUNT_WIDTH, 8, width of NUM_EVENTS and EVENTS_SENT.
HAS_STOP, 1, 1 = STOP port honoured; 0 = STOP ignored (tied FALSE internally).

Ports:
ACLK  in  1  clock; all logic on posedge.
ARESET  in  1  reset; synchronous, active-high.
START  in  1  start request; accepted only when BUSY=0.
STOP  in  1  abort request; effective only when BUSY=1.
PERIOD  in  PERIOD_WIDTH  cycles per event; sampled at START acceptance.
HIGH_TIME  in  PERIOD_WIDTH  cycles TICK is high per event; sampled at START acceptance.
NUM_EVENTS  in  COUNT_WIDTH  events to emit; 0 = free-running; sampled at START acceptance.
TICK  out  1  registered event output.
BUSY  out  1  train in progress.
DONE  out  1  one-cycle pulse after the last event of a finite train.
EVENTS_SENT  out  COUNT_WIDTH  events emitted since the last accepted START.

Behaviour:
- Reset (ARESET=1 at an edge): state IDLE; TICK=0, BUSY=0, DONE=0, EVENTS_SENT=0. Reset overrides everything, including mid-train.
- States:
  - IDLE --START--> HIGH.
  - HIGH --high counter expires--> LOW, or back to HIGH for the next event if LOW length is 0.
  - LOW --period expires--> HIGH (next event) or IDLE (train complete).
  - Any busy state --STOP--> IDLE.
- START acceptance at edge k while BUSY=0 and STOP=0:
  - Latch p = max(PERIOD,1), h = min(max(HIGH_TIME,1), p), n = NUM_EVENTS.
  - Clear EVENTS_SENT.
  - Edge k+1 onward: BUSY=1 and TICK=1.
- Each event occupies exactly p cycles: TICK=1 for h cycles, then 0 for p-h cycles.
  - h = p keeps TICK high continuously across events.
  - Counting is by event slots, not TICK edges.
- EVENTS_SENT increments by 1 in the first cycle of each event slot; it is visible the same cycle TICK rises for that slot.
  - Wraps modulo 2^COUNT_WIDTH when n=0.
  - Holds its value after completion or abort until the next accepted START.
- Completion (n≠0): after the last cycle of event n, the next cycle has BUSY=0, TICK=0, DONE=1 for exactly one cycle.
  - START is accepted in that DONE cycle; back-to-back trains therefore have a one-cycle gap.
- STOP while BUSY (HAS_STOP=1): next cycle TICK=0, BUSY=0, DONE stays 0; EVENTS_SENT keeps its partial count.
- STOP and START in the same IDLE cycle: STOP wins and START is ignored. STOP while IDLE has no effect.
- START while BUSY: ignored. PERIOD, HIGH_TIME and NUM_EVENTS changes mid-train: no effect.
- Phase counter is PERIOD_WIDTH bits and never overflows, since p ≤ 2^PERIOD_WIDTH-1.
- Event counter comparison is full-width equality to n.
- Latency: START edge to first TICK high is 1 cycle.

Decomposition:
- Package event_gen_pkg:
  - State encoding constants: ST_IDLE, ST_HIGH, ST_LOW (2 bits).
  - TRUE/FALSE constants.
- Sub-module tick_timer:
  - Loadable down-counter with LOAD, LOAD_VAL, EXPIRED.
  - Instantiated once and reloaded with h at slot start and p-h at the HIGH→LOW boundary.
- The top level holds the FSM, the parameter latches and EVENTS_SENT.

Test Plan:
- P=4, H=1, N=3, START at cycle 0 → TICK=1 at cycles 1, 5, 9 only; BUSY=1 cycles 1–12; DONE=1 at cycle 13 only; EVENTS_SENT=3 from cycle 9, holding 3 afterward.
- P=3, H=3, N=2 → TICK=1 continuously cycles 1–6; DONE at cycle 7; EVENTS_SENT steps 1→2 at cycle 4.
- P=0, H=0, N=4 → treated as p=1, h=1: TICK=1 cycles 1–4; DONE at cycle 5.
- P=5, H=2, N=0, STOP at cycle 12 → TICK high at cycles 1–2, 6–7, 11–12; TICK=0 and BUSY=0 from cycle 13; no DONE; EVENTS_SENT=3.
- START reasserted in the DONE cycle of a P=2, H=1, N=1 train → second TICK one cycle after DONE; EVENTS_SENT resets to 0, then reads 1.
- ARESET=1 at cycle 6 of a P=4 train → cycle 7: TICK=0, BUSY=0, DONE=0, EVENTS_SENT=0; START held during reset is ignored.

Source files
------------

// File: rtl/event_gen_pkg.sv
// Shared definitions for the event generator: FSM state encoding and boolean constants.
package event_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/event_generator_tick_timer.sv
// Loadable down-counter: a load of V makes EXPIRED assert in the V-th cycle after the load.
module tick_timer #(
    parameter int WIDTH = 8
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic             EXPIRED
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge ACLK) begin
        if (ARESET)
            count <= '0;
        else if (LOAD)
            count <= LOAD_VAL;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign EXPIRED = (count == WIDTH'(1));

endmodule

// File: rtl/event_generator.sv
// Programmable tick source: emits fixed-length or free-running trains of TICK pulses.
import event_gen_pkg::*;

module event_generator #(
    parameter int PERIOD_WIDTH = 8,
    parameter int COUNT_WIDTH  = 8,
    parameter int HAS_STOP     = 1
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    START,
    input  logic                    STOP,
    input  logic [PERIOD_WIDTH-1:0] PERIOD,
    input  logic [PERIOD_WIDTH-1:0] HIGH_TIME,
    input  logic [COUNT_WIDTH-1:0]  NUM_EVENTS,
    output logic                    TICK,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [COUNT_WIDTH-1:0]  EVENTS_SENT
);

    state_t                  state, state_next;
    logic                    stop_eff, accept, end_slot, expired, load, done_next;
    logic [PERIOD_WIDTH-1:0] p_in, h_raw, h_in, load_val;
    logic [PERIOD_WIDTH-1:0] h_q, low_q;
    logic [COUNT_WIDTH-1:0]  n_q, ev_q, ev_next;
    logic                    tick_q, busy_q, done_q;

    assign stop_eff = (HAS_STOP != 0) ? STOP : FALSE;

    // Zero period/high time are promoted to 1; high time never exceeds the period.
    assign p_in  = (PERIOD == '0) ? PERIOD_WIDTH'(1) : PERIOD;
    assign h_raw = (HIGH_TIME == '0) ? PERIOD_WIDTH'(1) : HIGH_TIME;
    assign h_in  = (h_raw > p_in) ? p_in : h_raw;

    tick_timer #(.WIDTH(PERIOD_WIDTH)) u_timer (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .LOAD     (load),
        .LOAD_VAL (load_val),
        .EXPIRED  (expired)
    );

    always_comb begin
        state_next = state;
        load       = FALSE;
        load_val   = h_q;
        ev_next    = ev_q;
        done_next  = FALSE;
        accept     = FALSE;
        end_slot   = FALSE;
        case (state)
            ST_IDLE: begin
                if (START && !stop_eff) begin
                    accept     = TRUE;
                    state_next = ST_HIGH;
                    load       = TRUE;
                    load_val   = h_in;
                    ev_next    = COUNT_WIDTH'(1);
                end
            end
            ST_HIGH: begin
                if (stop_eff)
                    state_next = ST_IDLE;
                else if (expired) begin
                    if (low_q != '0) begin
                        state_next = ST_LOW;
                        load       = TRUE;
                        load_val   = low_q;
                    end else
                        end_slot = TRUE;
                end
            end
            ST_LOW: begin
                if (stop_eff)
                    state_next = ST_IDLE;
                else if (expired)
                    end_slot = TRUE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Slot boundary: finish a finite train or open the next slot (counted on entry).
        if (end_slot) begin
            if (n_q != '0 && ev_q == n_q) begin
                state_next = ST_IDLE;
                done_next  = TRUE;
            end else begin
                state_next = ST_HIGH;
                load       = TRUE;
                load_val   = h_q;
                ev_next    = ev_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state  <= ST_IDLE;
            tick_q <= FALSE;
            busy_q <= FALSE;
            done_q <= FALSE;
            ev_q   <= '0;
            h_q    <= '0;
            low_q  <= '0;
            n_q    <= '0;
        end else begin
            state  <= state_next;
            tick_q <= (state_next == ST_HIGH);
            busy_q <= (state_next != ST_IDLE);
            done_q <= done_next;
            ev_q   <= ev_next;
            if (accept) begin
                h_q   <= h_in;
                low_q <= p_in - h_in;
                n_q   <= NUM_EVENTS;
            end
        end
    end

    assign TICK        = tick_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign EVENTS_SENT = ev_q;

endmodule

// File: tb/tb_event_generator.sv
// Scoreboard bench for event_generator: expected {TICK,BUSY,DONE,EVENTS_SENT} queued per cycle.
module tb_event_generator;

    logic       ACLK = 1'b0;
    logic       ARESET, START, STOP;
    logic [7:0] PERIOD, HIGH_TIME, NUM_EVENTS;
    logic       TICK, BUSY, DONE;
    logic [7:0] EVENTS_SENT;

    int n_checks = 0;
    int n_fail   = 0;
    logic [10:0] exp_q[$];
    logic [10:0] act_q[$];

    always #5 ACLK = ~ACLK;

    event_generator #(.PERIOD_WIDTH(8), .COUNT_WIDTH(8), .HAS_STOP(1)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .START(START), .STOP(STOP),
        .PERIOD(PERIOD), .HIGH_TIME(HIGH_TIME), .NUM_EVENTS(NUM_EVENTS),
        .TICK(TICK), .BUSY(BUSY), .DONE(DONE), .EVENTS_SENT(EVENTS_SENT)
    );

    // Closed-form reference: cycle c (START seen at the edge ending cycle 0).
    function automatic logic [10:0] model(int c, int pr, int hr, int n, int stop, int s2, int prev);
        int pe, he, slot, off;
        logic [7:0] ev;
        pe = (pr == 0) ? 1 : pr;
        he = (hr == 0) ? 1 : hr;
        if (he > pe) he = pe;
        if (s2 >= 0 && c > s2) c = c - s2;
        if (stop == 0) begin
            ev = prev[7:0];
            return {3'b000, ev};
        end
        if (stop > 0 && c > stop) begin
            ev = 8'(((stop - 1) / pe) + 1);
            return {3'b000, ev};
        end
        ev = 8'(n);
        if (n != 0 && c == n * pe + 1) return {3'b001, ev};
        if (n != 0 && c >  n * pe + 1) return {3'b000, ev};
        slot = (c - 1) / pe;
        off  = (c - 1) % pe;
        ev   = 8'(slot + 1);
        return {(off < he), 1'b1, 1'b0, ev};
    endfunction

    // Drives one train (optional STOP cycle, optional second START) and queues expected/actual.
    task automatic drive_train(input int pr, input int hr, input int n, input int stop,
                               input int s2, input int ncyc);
        for (int c = 0; c <= ncyc; c++) begin
            @(posedge ACLK); #1;
            START = (c == 0 || c == s2);
            STOP  = (c == stop);
            if (c == 0 || c == s2) begin
                PERIOD = 8'(pr); HIGH_TIME = 8'(hr); NUM_EVENTS = 8'(n);
            end else begin
                PERIOD = 8'($urandom); HIGH_TIME = 8'($urandom); NUM_EVENTS = 8'($urandom);
            end
            if (c >= 1) exp_q.push_back(model(c, pr, hr, n, stop, s2, 0));
            @(negedge ACLK);
            if (c >= 1) act_q.push_back({TICK, BUSY, DONE, EVENTS_SENT});
        end
        @(posedge ACLK); #1;
        START = 1'b0; STOP = 1'b0;
    endtask

    task automatic test_reset_state();
        ARESET = 1'b1; START = 1'b1; STOP = 1'b0;
        PERIOD = 8'd4; HIGH_TIME = 8'd1; NUM_EVENTS = 8'd0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        n_checks++;
        if ({TICK, BUSY, DONE, EVENTS_SENT} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 000", {TICK, BUSY, DONE, EVENTS_SENT});
        end
        @(posedge ACLK); #1;
        ARESET = 1'b0; START = 1'b0;
    endtask

    task automatic test_basic();
        logic [10:0] e, a;
        drive_train(4, 1, 3, -1, -1, 16);
        for (int i = 1; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL basic cycle %0d: got %h want %h", i, a, e); end
        end
    endtask

    task automatic test_full_high();
        logic [10:0] e, a;
        drive_train(3, 3, 2, -1, -1, 9);
        for (int i = 1; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL full_high cycle %0d: got %h want %h", i, a, e); end
        end
    endtask

    task automatic test_clamp_high();
        logic [10:0] e, a;
        drive_train(3, 7, 2, -1, -1, 9);
        for (int i = 1; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL clamp_high cycle %0d: got %h want %h", i, a, e); end
        end
    endtask

    task automatic test_zero_params();
        logic [10:0] e, a;
        drive_train(0, 0, 4, -1, -1, 7);
        for (int i = 1; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL zero_params cycle %0d: got %h want %h", i, a, e); end
        end
    endtask

    task automatic test_stop();
        logic [10:0] e, a;
        drive_train(5, 2, 0, 12, -1, 16);
        for (int i = 1; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL stop cycle %0d: got %h want %h", i, a, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] e, a;
        drive_train(2, 1, 1, -1, 3, 8);
        for (int i = 1; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL back_to_back cycle %0d: got %h want %h", i, a, e); end
        end
    endtask

    task automatic test_wrap();
        logic [10:0] e, a;
        drive_train(1, 1, 0, 258, -1, 262);
        for (int i = 1; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL wrap cycle %0d: got %h want %h", i, a, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] e, a;
        for (int c = 0; c <= 8; c++) begin
            @(posedge ACLK); #1;
            START  = (c == 0 || c == 6);
            ARESET = (c == 6);
            STOP   = 1'b0;
            PERIOD = 8'd4; HIGH_TIME = 8'd1; NUM_EVENTS = 8'd0;
            if (c == 5) exp_q.push_back(model(5, 4, 1, 0, -1, -1, 0));
            if (c >= 7) exp_q.push_back(11'd0);
            @(negedge ACLK);
            if (c == 5 || c >= 7) act_q.push_back({TICK, BUSY, DONE, EVENTS_SENT});
        end
        START = 1'b0;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL reset_mid sample %0d: got %h want %h", i, a, e); end
        end
    endtask

    task automatic test_stop_start_idle();
        logic [10:0] e, a;
        drive_train(3, 1, 2, 0, -1, 4);
        for (int i = 1; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
            if (a !== e) begin n_fail++; $display("FAIL stop_start_idle cycle %0d: got %h want %h", i, a, e); end
        end
    endtask

    initial begin
        test_reset_state();
        test_basic();
        test_full_high();
        test_clamp_high();
        test_zero_params();
        test_stop();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_stop_start_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
